// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: builds the leader/data/stop/guard envelope
// and gates the external carrier onto the LED output.
module nec_ir_tx #(
  parameter int UNIT_CYCLES = 28_125,
  parameter int GAP_UNITS   = 72
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nec_clk,
  input  logic       start,
  input  logic       rpt,
  input  logic [7:0] addr,
  input  logic [7:0] cmd,
  output logic       ready,
  output logic       busy,
  output logic       envelope,
  output logic       ir_out,
  output logic       done
);

  localparam int UCW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [UCW-1:0] UCNT_LAST = UCW'(UNIT_CYCLES - 1);
  localparam logic [6:0]     GAP_LEN   = 7'(GAP_UNITS);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [UCW-1:0] ucnt;
  logic [6:0]     scnt;
  logic [31:0]    shreg;
  logic [4:0]     bit_idx;
  logic           rpt_q;
  logic [6:0]     state_len;
  logic           unit_tick;
  logic           state_end;
  logic           env_nxt;
  logic           done_nxt;

  // Length of the current state in NEC units; a data bit's space length
  // is chosen by the bit currently at the bottom of the shift register.
  always_comb begin
    state_len = 7'd1;
    case (state)
      LEAD_MARK:  state_len = 7'd16;
      LEAD_SPACE: state_len = rpt_q ? 7'd4 : 7'd8;
      BIT_SPACE:  state_len = shreg[0] ? 7'd3 : 7'd1;
      GAP:        state_len = GAP_LEN;
      default:    state_len = 7'd1;
    endcase
  end

  assign unit_tick = (ucnt == UCNT_LAST);
  assign state_end = unit_tick && (scnt == state_len - 7'd1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      envelope <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      envelope <= env_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = LEAD_MARK;
      LEAD_MARK:  if (state_end) state_nxt = LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_nxt = rpt_q ? STOP_MARK : BIT_MARK;
      BIT_MARK:   if (state_end) state_nxt = BIT_SPACE;
      BIT_SPACE:  if (state_end) state_nxt = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (state_end) state_nxt = GAP;
      GAP:        if (state_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Envelope is derived from the next state so it changes on the same edge
  // as the state itself, keeping it registered and glitch-free.
  always_comb begin
    env_nxt  = 1'b0;
    done_nxt = 1'b0;
    ready    = (state == IDLE);
    busy     = (state != IDLE);
    case (state_nxt)
      LEAD_MARK, BIT_MARK, STOP_MARK: env_nxt = 1'b1;
      default:                        env_nxt = 1'b0;
    endcase
    if ((state == GAP) && state_end) done_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ucnt    <= '0;
      scnt    <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      rpt_q   <= 1'b0;
    end else if (state == IDLE) begin
      ucnt <= '0;
      scnt <= '0;
      if (start) begin
        shreg   <= {~cmd, cmd, ~addr, addr};
        rpt_q   <= rpt;
        bit_idx <= '0;
      end
    end else if (state_end) begin
      ucnt <= '0;
      scnt <= '0;
      if (state == BIT_SPACE) begin
        shreg   <= {1'b0, shreg[31:1]};
        bit_idx <= bit_idx + 5'd1;
      end
    end else if (unit_tick) begin
      ucnt <= '0;
      scnt <= scnt + 7'd1;
    end else begin
      ucnt <= ucnt + UCW'(1);
    end
  end

  assign ir_out = envelope & nec_clk;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx with a short unit (4 cycles) and 2-unit guard;
// expected envelopes come from a segment list built from the NEC frame rules.
module tb_nec_ir_tx;

  localparam int U   = 4;
  localparam int GAP = 2;

  logic       clk;
  logic       reset_n;
  logic       nec_clk;
  logic       start;
  logic       rpt;
  logic [7:0] addr;
  logic [7:0] cmd;
  logic       ready;
  logic       busy;
  logic       envelope;
  logic       ir_out;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;
  int seg_lvl[$];
  int seg_units[$];

  nec_ir_tx #(
    .UNIT_CYCLES(U),
    .GAP_UNITS  (GAP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .nec_clk (nec_clk),
    .start   (start),
    .rpt     (rpt),
    .addr    (addr),
    .cmd     (cmd),
    .ready   (ready),
    .busy    (busy),
    .envelope(envelope),
    .ir_out  (ir_out),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Carrier toggles every cycle, offset from the clock edge.
  initial begin
    nec_clk = 1'b0;
    forever begin
      @(posedge clk);
      #2 nec_clk = ~nec_clk;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic push_seg(input int lvl, input int units);
    seg_lvl.push_back(lvl);
    seg_units.push_back(units);
  endtask

  task automatic build_model(input logic [7:0] a, input logic [7:0] c, input logic r);
    logic [31:0] d;
    seg_lvl.delete();
    seg_units.delete();
    d = {~c, c, ~a, a};
    push_seg(1, 16);
    if (r) begin
      push_seg(0, 4);
    end else begin
      push_seg(0, 8);
      for (int i = 0; i < 32; i++) begin
        push_seg(1, 1);
        push_seg(0, d[i] ? 3 : 1);
      end
    end
    push_seg(1, 1);
    push_seg(0, GAP);
  endtask

  // Caller has start=1 set at a negedge with ready=1; the next posedge accepts.
  task automatic run_frame(input string tag, input bit hold, input int poke_at,
                           input int exp_total);
    int k           = 0;
    int busy_cycles = 0;
    int bad_env;
    int bad_ir;
    int bad_hs;
    bit lvl;
    for (int s = 0; s < seg_lvl.size(); s++) begin
      bad_env = 0;
      bad_ir  = 0;
      bad_hs  = 0;
      lvl     = (seg_lvl[s] != 0);
      for (int c = 0; c < seg_units[s] * U; c++) begin
        @(negedge clk);
        if (envelope !== lvl) bad_env++;
        if (ir_out !== (lvl & nec_clk)) bad_ir++;
        if (ready !== 1'b0 || done !== 1'b0) bad_hs++;
        if (busy === 1'b1) busy_cycles++;
        start = hold || (k == poke_at);
        if (k == poke_at) begin
          addr = 8'hFF;
          cmd  = 8'h00;
          rpt  = 1'b1;
        end
        k++;
      end
      check_output($sformatf("%s seg%0d envelope bad cycles", tag, s), bad_env, 0);
      check_output($sformatf("%s seg%0d ir_out bad cycles", tag, s), bad_ir, 0);
      check_output($sformatf("%s seg%0d ready/done bad cycles", tag, s), bad_hs, 0);
    end
    check_output({tag, " busy cycles"}, busy_cycles, exp_total);
    @(negedge clk);
    check_output({tag, " done at end"}, {31'd0, done}, 1);
    check_output({tag, " ready at end"}, {31'd0, ready}, 1);
    check_output({tag, " busy at end"}, {31'd0, busy}, 0);
    check_output({tag, " envelope at end"}, {31'd0, envelope}, 0);
    if (!hold) begin
      @(negedge clk);
      check_output({tag, " done after"}, {31'd0, done}, 0);
      check_output({tag, " ready after"}, {31'd0, ready}, 1);
      check_output({tag, " envelope after"}, {31'd0, envelope}, 0);
      check_output({tag, " ir_out after"}, {31'd0, ir_out}, 0);
    end
  endtask

  initial begin
    int bad;
    reset_n = 1'b0;
    start   = 1'b0;
    rpt     = 1'b0;
    addr    = 8'h00;
    cmd     = 8'h00;

    // Reset with carrier running.
    repeat (5) @(negedge clk);
    check_output("reset ready", {31'd0, ready}, 1);
    check_output("reset busy", {31'd0, busy}, 0);
    check_output("reset envelope", {31'd0, envelope}, 0);
    check_output("reset ir_out", {31'd0, ir_out}, 0);
    check_output("reset done", {31'd0, done}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_output("idle ready", {31'd0, ready}, 1);
    check_output("idle envelope", {31'd0, envelope}, 0);

    // Full frame 0x00/0xFF: 492 cycles to done.
    addr = 8'h00; cmd = 8'hFF; rpt = 1'b0; start = 1'b1;
    build_model(8'h00, 8'hFF, 1'b0);
    run_frame("full00FF", 1'b0, -1, 492);

    // Repeat code: addr/cmd ignored, 92 cycles to done.
    addr = 8'h12; cmd = 8'h34; rpt = 1'b1; start = 1'b1;
    build_model(8'h00, 8'h00, 1'b1);
    run_frame("repeat", 1'b0, -1, 92);

    // Mid-frame request with different data must be ignored.
    addr = 8'h81; cmd = 8'h6D; rpt = 1'b0; start = 1'b1;
    build_model(8'h81, 8'h6D, 1'b0);
    run_frame("poke", 1'b0, 150, 492);

    // Start held high: second frame accepted on the done cycle.
    addr = 8'h3C; cmd = 8'hA5; rpt = 1'b0; start = 1'b1;
    build_model(8'h3C, 8'hA5, 1'b0);
    run_frame("b2b first", 1'b1, -1, 492);
    addr = 8'hC7; cmd = 8'h18;
    build_model(8'hC7, 8'h18, 1'b0);
    run_frame("b2b second", 1'b0, -1, 492);

    // Reset during the first bit space (addr bit0 = 1, space spans k=100..111).
    addr = 8'h01; cmd = 8'h00; rpt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (101) @(negedge clk);
    check_output("pre-reset busy", {31'd0, busy}, 1);
    check_output("pre-reset envelope", {31'd0, envelope}, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_output("midreset envelope", {31'd0, envelope}, 0);
    check_output("midreset ready", {31'd0, ready}, 1);
    check_output("midreset done", {31'd0, done}, 0);
    reset_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (envelope !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || ir_out !== 1'b0) bad++;
    end
    check_output("post-reset idle bad cycles", bad, 0);

    // Fresh frame after the abort.
    addr = 8'h5A; cmd = 8'hC3; rpt = 1'b0; start = 1'b1;
    build_model(8'h5A, 8'hC3, 1'b0);
    run_frame("after reset", 1'b0, -1, 492);

    // Carrier stays blocked while idle.
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (ir_out !== 1'b0 || envelope !== 1'b0) bad++;
    end
    check_output("idle gating bad cycles", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
